// File: rtl/oled_frame_arbiter_if.sv
// Pixel-stream bus between the generators / OLED driver and the frame arbiter.
`timescale 1ns/1ps
interface oled_frame_arbiter_if #(
   parameter int N_REQ = 3
);
   logic [12:0]         pixel_index;
   logic [N_REQ-1:0]    req;
   logic [16*N_REQ-1:0] oled_data_in;
   logic [N_REQ-1:0]    grant;
   logic [N_REQ-1:0]    frame_done;
   logic [15:0]         oled_data;

   // Generator / driver side
   modport master (
      output pixel_index, req, oled_data_in,
      input  grant, frame_done, oled_data
   );

   // Arbiter side
   modport slave (
      input  pixel_index, req, oled_data_in,
      output grant, frame_done, oled_data
   );
endinterface

// File: rtl/oled_frame_arbiter.sv
// Frame-boundary round-robin arbiter for the 96x64 OLED pixel stream.
// Ownership only changes when pixel_index returns to 0, so frames never tear;
// an owner keeps the screen for up to MAX_FRAMES frames while others wait.
`timescale 1ns/1ps
module oled_frame_arbiter #(
   parameter int          N_REQ        = 3,
   parameter int          FRAME_PIXELS = 6144,
   parameter int          MAX_FRAMES   = 4,
   parameter logic [15:0] BG_COLOUR    = 16'h0000
) (
   input logic                  clock_100mhz,
   input logic                  reset_n,
   oled_frame_arbiter_if.slave  bus
);

   localparam int PW = $clog2(N_REQ);

   // Reject parameter sets the pixel counter and owner encoding cannot cover.
   if (N_REQ < 2 || N_REQ > 8 || MAX_FRAMES < 1 || FRAME_PIXELS < 1 || FRAME_PIXELS > 8192) begin : g_bad_param
      $error("oled_frame_arbiter: unsupported parameter set");
   end

   typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    owner_q, owner_d;
   logic [PW-1:0]    rr_q, rr_d;
   logic [7:0]       held_q, held_d;
   logic [12:0]      pix_q;
   logic [N_REQ-1:0] done_q, done_d;
   logic [15:0]      data_q, data_d;

   logic             bnd;
   logic [N_REQ-1:0] owner_oh;
   logic [N_REQ-1:0] others;
   logic             found;
   logic [PW-1:0]    cand;

   // A boundary is the first cycle pixel_index reads 0; a held 0 is not a new frame.
   assign bnd      = (bus.pixel_index == 13'd0) && (pix_q != 13'd0);
   assign owner_oh = (state_q == OWNED) ? ({{(N_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;
   assign others   = bus.req & ~owner_oh;

   // Round-robin search over waiting requesters, starting just after rr pointer.
   always_comb begin
      found = 1'b0;
      cand  = rr_q;
      for (int off = 1; off <= N_REQ; off++) begin
         if (!found && others[(int'(rr_q) + off) % N_REQ]) begin
            found = 1'b1;
            cand  = PW'((int'(rr_q) + off) % N_REQ);
         end
      end
   end

   // State register: ownership, quota counter, rr pointer, boundary history, outputs.
   always_ff @(posedge clock_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= PW'(N_REQ - 1);
         held_q  <= 8'd0;
         pix_q   <= 13'h1FFF;
         done_q  <= '0;
         data_q  <= BG_COLOUR;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         held_q  <= held_d;
         pix_q   <= bus.pixel_index;
         done_q  <= done_d;
         data_q  <= data_d;
      end
   end

   // Next-state: decide the owner of the frame that starts on this boundary.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      held_d  = held_q;
      done_d  = '0;
      if (bnd) begin
         done_d = owner_oh;
         if (state_q == OWNED && bus.req[owner_q] &&
             (int'(held_q) < MAX_FRAMES || others == '0)) begin
            held_d = (held_q == 8'hFF) ? 8'hFF : held_q + 8'd1;
         end else if (found) begin
            state_d = OWNED;
            owner_d = cand;
            rr_d    = cand;
            held_d  = 8'd1;
         end else begin
            state_d = IDLE;
            held_d  = 8'd0;
         end
      end
   end

   // Outputs: grant from registered state; pixel 0 already muxed from the new owner.
   always_comb begin
      data_d = BG_COLOUR;
      if (state_d == OWNED) begin
         data_d = bus.oled_data_in[16*int'(owner_d) +: 16];
      end
      bus.grant      = owner_oh;
      bus.frame_done = done_q;
      bus.oled_data  = data_q;
   end

endmodule
